// File: rtl/audio_dac_sink_pkg.sv
// Shared types and constants for the audio DAC sink: sample pair layout,
// serialiser states and the I2S one-bit data delay.
package audio_pkg;

   localparam int AUDIO_W   = 16;
   localparam int I2S_DELAY = 1;

   typedef struct packed {
      logic signed [AUDIO_W-1:0] left;
      logic signed [AUDIO_W-1:0] right;
   } sample_pair_t;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FRAME = 2'd1,
      LEFT       = 2'd2,
      RIGHT      = 2'd3
   } ser_state_e;

endpackage

// File: rtl/audio_dac_sink_if.sv
// Sample-write handshake between the player FSM (master) and the DAC sink (slave).
interface audio_dac_sink_if #(
   parameter int DATA_W = 16
);
   logic                     write_s;
   logic                     write_ready;
   logic signed [DATA_W-1:0] writedata_left;
   logic signed [DATA_W-1:0] writedata_right;

   modport master (output write_s, output writedata_left, output writedata_right,
                   input  write_ready);
   modport slave  (input  write_s, input  writedata_left, input  writedata_right,
                   output write_ready);
endinterface

// File: rtl/audio_dac_sink_fifo.sv
// Synchronous FIFO with extra-MSB pointers; storage is not reset, only the pointers.
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [WIDTH-1:0]       i_data,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_level = r_wr_ptr - r_rd_ptr;
   assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/audio_dac_sink.sv
// Stereo sample sink: FIFO-buffers pairs from the player and shifts them
// MSB-first onto AUD_DACDAT in I2S format, timed by codec-mastered BCLK/LRCK.
module audio_dac_sink
   import audio_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 16
) (
   input  logic                   CLOCK_50,
   input  logic                   rst_n,
   audio_dac_sink_if.slave        wr,
   input  logic                   AUD_BCLK,
   input  logic                   AUD_DACLRCK,
   output logic                   AUD_DACDAT,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic [CNT_W-1:0]       underflow_cnt
);
   localparam int LW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic signed [DATA_W-1:0] left;
      logic signed [DATA_W-1:0] right;
   } pair_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [2:0]        r_bclk_sync;
   logic [2:0]        r_lrck_sync;
   logic              r_lock;
   logic              r_write_ready;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] r_hold_r;
   ser_state_e        r_state;
   ser_state_e        w_next_state;
   logic              w_bclk_fall, w_lrck_fall, w_lrck_rise;
   logic              w_frame_start, w_chan_right, w_shift_en;
   logic              w_push, w_pop, w_full, w_empty, w_lock_next, w_full_next;
   logic [LW-1:0]     w_level_next;
   pair_t             w_fifo_din, w_fifo_dout;

   // Bit [0] and [1] form the synchroniser, bit [2] is the edge-detect history.
   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         r_bclk_sync <= '0;
         r_lrck_sync <= '0;
      end else begin
         r_bclk_sync <= {r_bclk_sync[1:0], AUD_BCLK};
         r_lrck_sync <= {r_lrck_sync[1:0], AUD_DACLRCK};
      end
   end

   assign w_bclk_fall = r_bclk_sync[2] & ~r_bclk_sync[1];
   assign w_lrck_fall = r_lrck_sync[2] & ~r_lrck_sync[1];
   assign w_lrck_rise = ~r_lrck_sync[2] & r_lrck_sync[1];

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:       w_next_state = WAIT_FRAME;
         WAIT_FRAME: if (w_lrck_fall) w_next_state = LEFT;
         LEFT:       if (w_lrck_rise) w_next_state = RIGHT;
         RIGHT:      if (w_lrck_fall) w_next_state = LEFT;
         default:    w_next_state = IDLE;
      endcase
   end

   always_comb begin
      w_frame_start = 1'b0;
      w_chan_right  = 1'b0;
      w_shift_en    = 1'b0;
      case (r_state)
         WAIT_FRAME: w_frame_start = w_lrck_fall;
         LEFT: begin
            w_chan_right = w_lrck_rise;
            w_shift_en   = 1'b1;
         end
         RIGHT: begin
            w_frame_start = w_lrck_fall;
            w_shift_en    = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_fifo_din.left  = wr.writedata_left;
   assign w_fifo_din.right = wr.writedata_right;

   sync_fifo #(.DEPTH(DEPTH), .WIDTH(2*DATA_W)) u_fifo (
      .i_clk   (CLOCK_50),
      .i_rst_n (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_fifo_din),
      .o_data  (w_fifo_dout),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (fifo_level)
   );

   // Lock keeps a held request from being pushed twice; ready is computed from
   // next-cycle occupancy so it drops right after a push and rises right after a pop.
   assign w_push       = wr.write_s & r_write_ready & ~r_lock & ~w_full;
   assign w_pop        = w_frame_start & ~w_empty;
   assign w_lock_next  = w_push | (r_lock & wr.write_s);
   assign w_level_next = fifo_level + LW'(w_push) - LW'(w_pop);
   assign w_full_next  = (w_level_next == LW'(DEPTH));
   assign wr.write_ready = r_write_ready;

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         r_lock        <= 1'b0;
         r_write_ready <= 1'b1;
         underflow_cnt <= '0;
      end else begin
         r_lock        <= w_lock_next;
         r_write_ready <= ~w_full_next & ~w_lock_next;
         if (w_frame_start & w_empty) underflow_cnt <= sat_inc(underflow_cnt);
      end
   end

   // A load coinciding with a bclk_fall still emits the old MSB, so the new
   // word's MSB lands one BCLK after the LRCK edge.
   always_ff @(posedge CLOCK_50) begin
      if (w_frame_start) begin
         r_shift  <= w_empty ? '0 : w_fifo_dout.left;
         r_hold_r <= w_empty ? '0 : w_fifo_dout.right;
      end else if (w_chan_right) begin
         r_shift <= r_hold_r;
      end else if (w_shift_en & w_bclk_fall) begin
         r_shift <= {r_shift[DATA_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n)           AUD_DACDAT <= 1'b0;
      else if (w_bclk_fall) AUD_DACDAT <= w_shift_en ? r_shift[DATA_W-1] : 1'b0;
   end

endmodule

// File: tb/tb_audio_dac_sink.sv
// Directed bench for audio_dac_sink: a queue-based reference of the sink plus
// hand-computed expectations for reset, serial words, handshake and FIFO limits.
module tb_audio_dac_sink;
   import audio_pkg::*;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 8;
   localparam int CNT_W  = 16;
   localparam int HALF   = 8;   // CLOCK_50 cycles per BCLK half period
   localparam int SYNC   = 3;   // pin change to internal effect, in clock edges

   logic              clk;
   logic              rst_n;
   logic              AUD_BCLK;
   logic              AUD_DACLRCK;
   logic              AUD_DACDAT;
   logic [3:0]        fifo_level;
   logic [CNT_W-1:0]  underflow_cnt;

   audio_dac_sink_if #(.DATA_W(DATA_W)) wr_if ();

   audio_dac_sink #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .CLOCK_50      (clk),
      .rst_n         (rst_n),
      .wr            (wr_if),
      .AUD_BCLK      (AUD_BCLK),
      .AUD_DACLRCK   (AUD_DACLRCK),
      .AUD_DACDAT    (AUD_DACDAT),
      .fifo_level    (fifo_level),
      .underflow_cnt (underflow_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not reach its end (got timeout, need finish)");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   sample_pair_t    q[$];
   int              cyc = 0;
   int              lrck_at = -100;
   bit              lrck_dir = 1'b0;
   bit              m_ready = 1'b1;
   bit              m_lock = 1'b0;
   bit              m_in_frame = 1'b0;
   int              m_uf = 0;
   logic [DATA_W-1:0] m_cur_l = '0;
   logic [DATA_W-1:0] m_cur_r = '0;

   // Bench-side serial expectation and capture
   bit              chk_en = 1'b0;
   bit              dat_chk = 1'b0;
   bit              exp_bit = 1'b0;
   logic [DATA_W-1:0] cap_l = '0;
   logic [DATA_W-1:0] cap_r = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_loop();
      sample_pair_t p;
      bit push, fall, rise;
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) begin
            q.delete();
            m_uf = 0;
            m_ready = 1'b1;
            m_lock = 1'b0;
            m_in_frame = 1'b0;
         end else begin
            fall = (cyc == lrck_at + SYNC) && !lrck_dir;
            rise = (cyc == lrck_at + SYNC) && lrck_dir;
            push = wr_if.write_s && m_ready && !m_lock;
            if (fall) begin
               m_in_frame = 1'b1;
               if (q.size() > 0) begin
                  p = q.pop_front();
                  m_cur_l = p.left;
                  m_cur_r = p.right;
               end else begin
                  m_cur_l = '0;
                  m_cur_r = '0;
                  if (m_uf < (1 << CNT_W) - 1) m_uf++;
               end
            end
            if (rise && !m_in_frame) begin
               m_cur_r = '0;
            end
            if (push) begin
               p.left  = wr_if.writedata_left;
               p.right = wr_if.writedata_right;
               q.push_back(p);
            end
            m_lock  = push ? 1'b1 : (wr_if.write_s ? m_lock : 1'b0);
            m_ready = (q.size() < DEPTH) && !m_lock;
         end
      end
   endtask

   task automatic compare_loop();
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("fifo_level", fifo_level, q.size());
            chk("write_ready", wr_if.write_ready, m_ready);
            chk("underflow_cnt", underflow_cnt, m_uf);
            if (dat_chk) chk("AUD_DACDAT", AUD_DACDAT, m_in_frame ? exp_bit : 1'b0);
         end
      end
   endtask

   // One BCLK period starting with a falling edge; j==0 also moves LRCK.
   task automatic bclk_period(input bit ch, input int j);
      logic [DATA_W-1:0] word;
      @(posedge clk); #1;
      AUD_BCLK = 1'b0;
      if (j == 0) begin
         AUD_DACLRCK = ch;
         lrck_dir    = ch;
         lrck_at     = cyc;
         if (ch) cap_r = '0; else cap_l = '0;
      end
      repeat (SYNC) @(posedge clk);
      #1;
      word    = ch ? m_cur_r : m_cur_l;
      exp_bit = (j >= I2S_DELAY && j < I2S_DELAY + DATA_W) ? word[DATA_W-1-(j-I2S_DELAY)] : 1'b0;
      dat_chk = 1'b1;
      repeat (HALF - SYNC) @(posedge clk);
      #1;
      AUD_BCLK = 1'b1;
      if (j >= I2S_DELAY && j < I2S_DELAY + DATA_W) begin
         if (ch) cap_r = {cap_r[DATA_W-2:0], AUD_DACDAT};
         else    cap_l = {cap_l[DATA_W-2:0], AUD_DACDAT};
      end
      repeat (HALF - 1) @(posedge clk);
   endtask

   task automatic channel(input bit ch);
      for (int j = 0; j < 32; j++) bclk_period(ch, j);
   endtask

   task automatic frame();
      channel(1'b0);
      channel(1'b1);
   endtask

   task automatic push_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
      @(posedge clk); #1;
      wr_if.write_s         = 1'b1;
      wr_if.writedata_left  = l;
      wr_if.writedata_right = r;
      @(posedge clk); #1;
      wr_if.write_s = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n                 = 1'b0;
      AUD_BCLK              = 1'b1;
      AUD_DACLRCK           = 1'b1;
      wr_if.write_s         = 1'b0;
      wr_if.writedata_left  = '0;
      wr_if.writedata_right = '0;
      fork
         model_loop();
         compare_loop();
      join_none

      // Reset then idle
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk_en = 1'b1;
      chk("reset write_ready", wr_if.write_ready, 1);
      chk("reset fifo_level", fifo_level, 0);
      chk("reset AUD_DACDAT", AUD_DACDAT, 0);
      chk("reset underflow_cnt", underflow_cnt, 0);
      for (int f = 0; f < 3; f++) begin
         frame();
         chk("idle underflow_cnt", underflow_cnt, f + 1);
      end

      // Single pair
      push_pair(16'h8001, 16'h7FFE);
      chk("single level after push", fifo_level, 1);
      frame();
      chk("single left word", cap_l, 16'h8001);
      chk("single right word", cap_r, 16'h7FFE);
      chk("single level after pop", fifo_level, 0);
      chk("single underflow_cnt", underflow_cnt, 3);

      // Held write_s
      @(posedge clk); #1;
      wr_if.write_s         = 1'b1;
      wr_if.writedata_left  = 16'h1234;
      wr_if.writedata_right = 16'hABCD;
      repeat (20) @(posedge clk);
      #1;
      chk("held write_ready", wr_if.write_ready, 0);
      chk("held fifo_level", fifo_level, 1);
      wr_if.write_s = 1'b0;
      @(posedge clk); #1;
      chk("held release write_ready", wr_if.write_ready, 1);
      frame();
      chk("held left word", cap_l, 16'h1234);
      chk("held right word", cap_r, 16'hABCD);

      // Full FIFO with LRCK frozen
      for (int i = 0; i < DEPTH; i++) push_pair(16'h0100 + 16'(i), 16'hF000 + 16'(i));
      chk("full fifo_level", fifo_level, 8);
      chk("full write_ready", wr_if.write_ready, 0);
      @(posedge clk); #1;
      wr_if.write_s         = 1'b1;
      wr_if.writedata_left  = 16'hEEEE;
      wr_if.writedata_right = 16'hEEEE;
      repeat (5) @(posedge clk);
      #1;
      chk("full ninth rejected", fifo_level, 8);
      wr_if.write_s = 1'b0;
      channel(1'b0);
      chk("full level after pop", fifo_level, 7);
      chk("full write_ready after pop", wr_if.write_ready, 1);
      chk("full oldest left", cap_l, 16'h0100);

      // Simultaneous push and pop at level 3
      do_reset();
      chk("sim reset fifo_level", fifo_level, 0);
      push_pair(16'hA001, 16'hA002);
      push_pair(16'hB001, 16'hB002);
      push_pair(16'hC001, 16'hC002);
      chk("sim level 3", fifo_level, 3);
      channel(1'b1);
      fork
         channel(1'b0);
         begin
            repeat (SYNC) @(posedge clk);
            #1;
            wr_if.write_s         = 1'b1;
            wr_if.writedata_left  = 16'hD001;
            wr_if.writedata_right = 16'hD002;
            @(posedge clk); #1;
            wr_if.write_s = 1'b0;
         end
      join
      chk("sim level stays 3", fifo_level, 3);
      channel(1'b1);
      chk("sim oldest left", cap_l, 16'hA001);
      chk("sim oldest right", cap_r, 16'hA002);

      // Mid-frame reset around bit 7 of the left word
      fork
         channel(1'b0);
         begin
            repeat (7 * 2 * HALF + 6) @(posedge clk);
            #1;
            rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
         end
      join
      chk("midreset fifo_level", fifo_level, 0);
      chk("midreset AUD_DACDAT", AUD_DACDAT, 0);
      chk("midreset underflow_cnt", underflow_cnt, 0);
      channel(1'b1);
      frame();
      chk("midreset silence underflow", underflow_cnt, 1);
      chk("midreset silence left", cap_l, 16'h0000);
      chk("midreset silence right", cap_r, 16'h0000);

      repeat (4) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
